// File: rtl/irrigacao_controlador.sv
// Irrigation controller: tank fill, sprinkler and drip scheduling from
// synchronized level/soil/air/temperature sensors, with a 1-s tick base,
// per-state elapsed-time counter and a latched fill-timeout alarm.
module irrigacao_controlador #(
  parameter int DIV_TICK = 50_000_000,
  parameter int T_ASP    = 30,
  parameter int T_GOT    = 60,
  parameter int T_FILL   = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       H,
  input  logic       M,
  input  logic       L,
  input  logic       Us,
  input  logic       Ua,
  input  logic       T,
  output logic       Ve,
  output logic       Bs,
  output logic       Vs,
  output logic       Erro,
  output logic       Alarme,
  output logic [2:0] estado,
  output logic [7:0] tempo
);

  localparam int             PW         = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
  localparam logic [PW-1:0]  PRESC_MAX  = PW'(DIV_TICK - 1);
  localparam logic [7:0]     TEMPO_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ENCHER      = 3'd1,
    ASPERSAO    = 3'd2,
    GOTEJAMENTO = 3'd3,
    ERRO        = 3'd4
  } state_t;

  logic [5:0]    r_sync1;
  logic [5:0]    r_sync2;
  logic          r_vld1;
  logic          r_vld2;
  logic [PW-1:0] r_presc;
  state_t        r_state;
  state_t        w_next;
  logic [7:0]    r_tempo;
  logic          r_alarme;

  logic w_tick;
  logic w_h, w_m, w_l, w_us, w_ua, w_t;
  logic w_invalid;
  logic w_fill_to, w_asp_to, w_got_to;
  logic w_set_alarme;

  // Two-flop synchronizer for all sensors. A valid bit travels alongside the
  // data so the FSM holds in IDLE until real sampled values reach stage 2,
  // instead of acting on the all-zero reset contents (which read as "tank empty").
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_vld1  <= 1'b0;
      r_vld2  <= 1'b0;
    end else begin
      r_sync1 <= {H, M, L, Us, Ua, T};
      r_sync2 <= r_sync1;
      r_vld1  <= 1'b1;
      r_vld2  <= r_vld1;
    end
  end

  assign {w_h, w_m, w_l, w_us, w_ua, w_t} = r_sync2;

  // Free-running prescaler; tick is high during the last count of each period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (r_presc == PRESC_MAX) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign w_tick    = (r_presc == PRESC_MAX);
  assign w_invalid = (w_h & ~w_m) | (w_m & ~w_l);
  assign w_fill_to = (32'(r_tempo) >= 32'(T_FILL));
  assign w_asp_to  = (32'(r_tempo) >= 32'(T_ASP));
  assign w_got_to  = (32'(r_tempo) >= 32'(T_GOT));

  // Next-state decision; an inconsistent level combination overrides everything.
  always_comb begin
    w_next       = r_state;
    w_set_alarme = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_vld2) begin
          if (w_invalid)                  w_next = ERRO;
          else if (!w_m)                  w_next = ENCHER;
          else if (!w_us && w_t && !w_ua) w_next = ASPERSAO;
          else if (!w_us)                 w_next = GOTEJAMENTO;
        end
      end
      ENCHER: begin
        if (w_invalid) begin
          w_next = ERRO;
        end else if (w_h) begin
          w_next = IDLE;
        end else if (w_fill_to) begin
          w_next       = ERRO;
          w_set_alarme = 1'b1;
        end
      end
      ASPERSAO: begin
        if (w_invalid)              w_next = ERRO;
        else if (w_us || w_asp_to)  w_next = IDLE;
        else if (!w_m)              w_next = ENCHER;
      end
      GOTEJAMENTO: begin
        if (w_invalid)              w_next = ERRO;
        else if (w_us || w_got_to)  w_next = IDLE;
        else if (!w_l)              w_next = ENCHER;
      end
      ERRO: begin
        if (!w_invalid && !r_alarme) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Elapsed ticks in the current state; a state change clears it even on a tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tempo <= '0;
    end else if (w_next != r_state) begin
      r_tempo <= '0;
    end else if (w_tick && (r_tempo != TEMPO_MAX)) begin
      r_tempo <= r_tempo + 8'd1;
    end
  end

  // Fill-timeout alarm, sticky until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alarme <= 1'b0;
    end else if (w_set_alarme) begin
      r_alarme <= 1'b1;
    end
  end

  // Moore output decode; one-hot state decode keeps the valves exclusive.
  always_comb begin
    Ve     = (r_state == ENCHER);
    Bs     = (r_state == ASPERSAO);
    Vs     = (r_state == GOTEJAMENTO);
    Erro   = (r_state == ERRO);
    Alarme = r_alarme;
    estado = r_state;
    tempo  = r_tempo;
  end

endmodule

// File: tb/tb_irrigacao_controlador.sv
// Bench for irrigacao_controlador: directed vector table, a few hand-written
// sequences (async reset mid-irrigation, tempo saturation) and randomized
// stimulus compared every cycle against a behavioural reference model.
module tb_irrigacao_controlador;

  localparam int DIV = 4;
  localparam int TA  = 3;
  localparam int TG  = 5;
  localparam int TF  = 6;

  localparam int S_IDLE = 0;
  localparam int S_ENC  = 1;
  localparam int S_ASP  = 2;
  localparam int S_GOT  = 3;
  localparam int S_ERR  = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       H = 1'b0, M = 1'b0, L = 1'b0, Us = 1'b0, Ua = 1'b0, T = 1'b0;
  logic       Ve, Bs, Vs, Erro, Alarme;
  logic [2:0] estado;
  logic [7:0] tempo;

  int n_tests = 0;
  int n_fail  = 0;

  irrigacao_controlador #(
    .DIV_TICK (DIV),
    .T_ASP    (TA),
    .T_GOT    (TG),
    .T_FILL   (TF)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .H      (H),
    .M      (M),
    .L      (L),
    .Us     (Us),
    .Ua     (Ua),
    .T      (T),
    .Ve     (Ve),
    .Bs     (Bs),
    .Vs     (Vs),
    .Erro   (Erro),
    .Alarme (Alarme),
    .estado (estado),
    .tempo  (tempo)
  );

  always #5 clk = ~clk;

  // Packed observation: {estado[2:0], tempo[7:0], Ve, Bs, Vs, Erro, Alarme}
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %04h expected %04h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] observed();
    return {estado, tempo, Ve, Bs, Vs, Erro, Alarme};
  endfunction

  // Advance n rising edges, then settle 2 time units past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------- reference model ----------------
  // The controller reacts to what the sensors read two edges ago; the model
  // keeps that history explicitly and applies the state rules with integers.
  typedef struct packed {
    logic       v;
    logic [5:0] s;   // {H,M,L,Us,Ua,T}
  } samp_t;

  samp_t m_hist [2] = '{default: '0};
  int    m_state = S_IDLE;
  int    m_tempo = 0;
  int    m_div   = 0;
  bit    m_alarm = 1'b0;

  always @(posedge clk or posedge reset) begin : ref_model
    samp_t seen;
    int    nxt;
    bit    h, m, l, us, ua, t, bad, tick, al;
    if (reset) begin
      m_state   <= S_IDLE;
      m_tempo   <= 0;
      m_div     <= 0;
      m_alarm   <= 1'b0;
      m_hist[0] <= '0;
      m_hist[1] <= '0;
    end else begin
      seen = m_hist[1];
      {h, m, l, us, ua, t} = seen.s;
      bad  = (h && !m) || (m && !l);
      tick = (m_div == DIV - 1);
      nxt  = m_state;
      al   = m_alarm;
      if (seen.v) begin
        case (m_state)
          S_IDLE: begin
            if (bad)                    nxt = S_ERR;
            else if (!m)                nxt = S_ENC;
            else if (!us && t && !ua)   nxt = S_ASP;
            else if (!us)               nxt = S_GOT;
          end
          S_ENC: begin
            if (bad)                    nxt = S_ERR;
            else if (h)                 nxt = S_IDLE;
            else if (m_tempo >= TF) begin
              nxt = S_ERR;
              al  = 1'b1;
            end
          end
          S_ASP: begin
            if (bad)                        nxt = S_ERR;
            else if (us || m_tempo == TA)   nxt = S_IDLE;
            else if (!m)                    nxt = S_ENC;
          end
          S_GOT: begin
            if (bad)                        nxt = S_ERR;
            else if (us || m_tempo == TG)   nxt = S_IDLE;
            else if (!l)                    nxt = S_ENC;
          end
          default: begin
            if (!bad && !m_alarm)           nxt = S_IDLE;
          end
        endcase
      end
      m_hist[1] <= m_hist[0];
      m_hist[0] <= {1'b1, H, M, L, Us, Ua, T};
      m_div     <= (m_div + 1) % DIV;
      if (nxt != m_state)              m_tempo <= 0;
      else if (tick && m_tempo < 255)  m_tempo <= m_tempo + 1;
      m_state   <= nxt;
      m_alarm   <= al;
    end
  end

  function automatic logic [15:0] model_obs();
    logic [4:0] f;
    f = {m_state == S_ENC, m_state == S_ASP, m_state == S_GOT, m_state == S_ERR, m_alarm};
    return {3'(m_state), 8'(m_tempo), f};
  endfunction

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    check("model", observed(), model_obs());
    check("valves_exclusive", 16'($countones({Ve, Bs, Vs}) <= 1), 16'd1);
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         rst;
    bit [5:0]   in;   // {H,M,L,Us,Ua,T}
    int         cyc;  // 0: apply and look 1 time unit later (async reset)
    int         est;
    int         tmp;
    bit [4:0]   flg;  // {Ve,Bs,Vs,Erro,Alarme}
  } vec_t;

  vec_t tbl[$];

  bit [2:0] lv_ok  [4] = '{3'b000, 3'b001, 3'b011, 3'b111};
  bit [2:0] lv_bad [4] = '{3'b010, 3'b100, 3'b101, 3'b110};

  initial begin
    // Sprinkler: 3 ticks then IDLE, re-entry next cycle.
    tbl.push_back('{1'b1, 6'b111_001,  0, 0, 0, 5'b00000});
    tbl.push_back('{1'b0, 6'b111_001,  3, 2, 0, 5'b01000});
    tbl.push_back('{1'b0, 6'b111_001,  9, 2, 3, 5'b01000});
    tbl.push_back('{1'b0, 6'b111_001,  1, 0, 0, 5'b00000});
    tbl.push_back('{1'b0, 6'b111_001,  1, 2, 0, 5'b01000});
    // Drip: soil turns wet at tick 2, seen 3 edges later.
    tbl.push_back('{1'b1, 6'b111_000,  0, 0, 0, 5'b00000});
    tbl.push_back('{1'b0, 6'b111_000,  3, 3, 0, 5'b00100});
    tbl.push_back('{1'b0, 6'b111_000,  5, 3, 2, 5'b00100});
    tbl.push_back('{1'b0, 6'b111_100,  2, 3, 2, 5'b00100});
    tbl.push_back('{1'b0, 6'b111_100,  1, 0, 0, 5'b00000});
    // Fill, tank reaches H at tick 4.
    tbl.push_back('{1'b1, 6'b001_100,  0, 0, 0, 5'b00000});
    tbl.push_back('{1'b0, 6'b001_100,  3, 1, 0, 5'b10000});
    tbl.push_back('{1'b0, 6'b001_100, 13, 1, 4, 5'b10000});
    tbl.push_back('{1'b0, 6'b111_100,  2, 1, 4, 5'b10000});
    tbl.push_back('{1'b0, 6'b111_100,  1, 0, 0, 5'b00000});
    // Fill timeout: alarm latches, ERRO holds even with good levels.
    tbl.push_back('{1'b1, 6'b000_100,  0, 0, 0, 5'b00000});
    tbl.push_back('{1'b0, 6'b000_100,  3, 1, 0, 5'b10000});
    tbl.push_back('{1'b0, 6'b000_100, 21, 1, 6, 5'b10000});
    tbl.push_back('{1'b0, 6'b000_100,  1, 4, 0, 5'b00011});
    tbl.push_back('{1'b0, 6'b111_100,  8, 4, 2, 5'b00011});
    // Invalid level combination during drip, then recovery.
    tbl.push_back('{1'b1, 6'b111_000,  0, 0, 0, 5'b00000});
    tbl.push_back('{1'b0, 6'b111_000,  3, 3, 0, 5'b00100});
    tbl.push_back('{1'b0, 6'b101_000,  2, 3, 1, 5'b00100});
    tbl.push_back('{1'b0, 6'b101_000,  1, 4, 0, 5'b00010});
    tbl.push_back('{1'b0, 6'b111_000,  2, 4, 1, 5'b00010});
    tbl.push_back('{1'b0, 6'b111_000,  1, 0, 0, 5'b00000});

    step(2);
    foreach (tbl[i]) begin
      reset = tbl[i].rst;
      {H, M, L, Us, Ua, T} = tbl[i].in;
      if (tbl[i].cyc == 0) #1;
      else step(tbl[i].cyc);
      check($sformatf("vec%0d", i), observed(),
            {3'(tbl[i].est), 8'(tbl[i].tmp), tbl[i].flg});
    end

    // Async reset pulse between edges while sprinkling.
    reset = 1'b1;
    {H, M, L, Us, Ua, T} = 6'b111_001;
    #1 reset = 1'b0;
    step(5);
    check("pre_pulse_asp", observed(), {3'd2, 8'd1, 5'b01000});
    reset = 1'b1;
    #1;
    check("async_reset_pulse", observed(), {3'd0, 8'd0, 5'b00000});
    #1 reset = 1'b0;
    step(3);
    check("post_pulse_asp", observed(), {3'd2, 8'd0, 5'b01000});

    // Tempo saturation: IDLE with wet soil never leaves.
    reset = 1'b1;
    {H, M, L, Us, Ua, T} = 6'b111_100;
    #1 reset = 1'b0;
    step(1030);
    check("tempo_saturate", observed(), {3'd0, 8'd255, 5'b00000});
    step(8);
    check("tempo_hold_255", observed(), {3'd0, 8'd255, 5'b00000});

    // Randomized segments; every cycle is compared by the model checker.
    for (int seg = 0; seg < 6; seg++) begin
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 5) == 0) {H, M, L} = lv_bad[$urandom_range(0, 3)];
          else                           {H, M, L} = lv_ok[$urandom_range(0, 3)];
        end
        if ($urandom_range(0, 5) == 0) Us = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 5) == 0) Ua = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 5) == 0) T  = 1'($urandom_range(0, 1));
        step(1);
        if ($urandom_range(0, 299) == 0) begin
          reset = 1'b1;
          #1 reset = 1'b0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irrigacao_controlador.md
IRRIGACAO_CONTROLADOR -- requirements
Module: irrigacao_controlador

Interface
REQ-001 SHALL have parameter DIV_TICK, default 50_000_000, meaning clk cycles per 1-s tick.
REQ-002 SHALL have parameter T_ASP, default 30, meaning maximum sprinkler run in ticks.
REQ-003 SHALL have parameter T_GOT, default 60, meaning maximum drip run in ticks.
REQ-004 SHALL have parameter T_FILL, default 120, meaning maximum fill time in ticks before alarm.
REQ-005 SHALL have port clk  in  1  system clock; single clock domain, rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports H, M, L  in  1 each  tank level sensors (high/medium/low; 1 = water at sensor).
REQ-008 SHALL have ports Us, Ua, T  in  1 each  soil humidity (1 = wet), air humidity (1 = humid), temperature (1 = hot).
REQ-009 SHALL have ports Ve, Bs, Vs  out  1 each  inlet valve, sprinkler, drip valve.
REQ-010 SHALL have ports Erro, Alarme  out  1 each  sensor-inconsistency flag, latched fill-timeout alarm.
REQ-011 SHALL have port estado  out  3  current FSM state code.
REQ-012 SHALL have port tempo  out  8  ticks elapsed in current state, saturating at 255.

Function
REQ-013 SHALL pass all six sensor inputs through a 2-flop synchronizer; FSM uses only synchronized values.
REQ-014 SHALL generate a one-cycle tick every DIV_TICK clk cycles from a free-running prescaler.
REQ-015 SHALL implement states IDLE=0, ENCHER=1, ASPERSAO=2, GOTEJAMENTO=3, ERRO=4; codes 5-7 go to IDLE next cycle.
REQ-016 SHALL treat level combo as invalid when (H & !M) | (M & !L).
REQ-017 From any state except ERRO, an invalid level combo SHALL force ERRO next cycle (highest priority).
REQ-018 IDLE priority: invalid -> ERRO; else !M -> ENCHER; else !Us & T & !Ua -> ASPERSAO; else !Us -> GOTEJAMENTO; else stay.
REQ-019 ENCHER SHALL go to IDLE when H=1; when tempo reaches T_FILL with H=0, SHALL set Alarme and go to ERRO.
REQ-020 ASPERSAO SHALL go to IDLE on Us=1 or tempo=T_ASP; to ENCHER on M=0.
REQ-021 GOTEJAMENTO SHALL go to IDLE on Us=1 or tempo=T_GOT; to ENCHER on L=0.
REQ-022 ERRO SHALL go to IDLE the cycle after level combo is valid, unless Alarme=1, in which case it stays until reset.
REQ-023 Outputs SHALL be Moore decodes of state register: Ve=1 only in ENCHER; Bs=1 only in ASPERSAO; Vs=1 only in GOTEJAMENTO; Erro=1 only in ERRO.
REQ-024 Ve, Bs, Vs SHALL be mutually exclusive in every cycle.
REQ-025 tempo SHALL clear to 0 on the cycle of any state change and increment by 1 on each tick otherwise, saturating at 255.
REQ-026 A tick coinciding with a state change SHALL be ignored by tempo (clear wins).
REQ-027 Latency: a sensor change before clk edge n SHALL be reflected on outputs after edge n+2.
REQ-028 Alarme, once set, SHALL remain 1 until reset.

Reset
REQ-029 reset=1 SHALL asynchronously force state IDLE, tempo=0, prescaler=0, synchronizers=0, Alarme=0, hence Ve=Bs=Vs=Erro=0, estado=0.
REQ-030 Reset asserted mid-irrigation or mid-fill SHALL close all valves immediately, without waiting for a clock edge.
REQ-031 After reset deassertion, the first FSM decision SHALL use synchronized values (2 edges later).

Verification (DIV_TICK=4, T_ASP=3, T_GOT=5, T_FILL=6)
REQ-032 H=M=L=1, Us=0, T=1, Ua=0 -> ASPERSAO, Bs=1 for 3 ticks, then IDLE, re-enters ASPERSAO next cycle (Us still 0).
REQ-033 H=M=L=1, Us=0, T=0 -> GOTEJAMENTO, Vs=1; Us->1 at tick 2 -> Vs=0 and estado=0 after 3 edges.
REQ-034 H=0, M=0, L=1 -> ENCHER, Ve=1; H=M=1 raised at tick 4 -> IDLE, tempo=0.
REQ-035 M=0 held, H never 1 -> tempo reaches 6, Alarme=1, estado=4, Ve=0; restoring levels keeps ERRO until reset.
REQ-036 H=1, M=0, L=1 during GOTEJAMENTO -> ERRO, Erro=1, Vs=0; valid combo restored -> IDLE one cycle later.
REQ-037 reset pulsed mid-ASPERSAO between clock edges -> Bs=0, estado=0, tempo=0 before next edge.
